// File: rtl/instruktion_lader_pkg.sv
// Shared encodings and constants for the UART boot loader.
// Imported by the receiver and by the loader top level.
package instruktion_lader_pkg;

    localparam int TAKTE_PRO_BIT_STD = 217;
    localparam int BYTES_PRO_WORT    = 4;

    typedef enum logic [1:0] {
        U_RUHE,
        U_START,
        U_DATEN,
        U_STOP
    } uart_zustand_t;

    typedef enum logic [2:0] {
        L_KOPF,
        L_SAMMELN,
        L_SCHREIBEN,
        L_NACHLAUF,
        L_FERTIG
    } lader_zustand_t;

endpackage

// File: rtl/instruktion_lader_uart_empfaenger.sv
// 8N1 UART receiver with a two-flop input synchroniser.
// Emits a one-cycle strobe per good byte and per framing error.
module instruktion_lader_uart_empfaenger
    import instruktion_lader_pkg::*;
#(
    parameter int TAKTE_PRO_BIT = TAKTE_PRO_BIT_STD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] empf_byte,
    output logic       byte_gueltig,
    output logic       rahmenfehler
);

    localparam int ZW = $clog2(TAKTE_PRO_BIT);
    localparam logic [ZW-1:0] Z_BIT  = ZW'(TAKTE_PRO_BIT - 1);
    localparam logic [ZW-1:0] Z_HALB = ZW'(TAKTE_PRO_BIT / 2 - 1);

    logic          rx_p0, rx_p1, rx_p2;
    uart_zustand_t zustand, zustand_n;
    logic [ZW-1:0] zaehler, zaehler_n;
    logic [2:0]    bit_nr, bit_nr_n;
    logic [7:0]    schiebe, schiebe_n;
    logic          gueltig_n, fehler_n;

    // Synchroniser stage p0/p1; p2 is only the previous value for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    always_comb begin
        zustand_n = zustand;
        zaehler_n = zaehler + ZW'(1);
        bit_nr_n  = bit_nr;
        schiebe_n = schiebe;
        gueltig_n = 1'b0;
        fehler_n  = 1'b0;
        unique case (zustand)
            U_RUHE: begin
                zaehler_n = '0;
                if (rx_p2 && !rx_p1) zustand_n = U_START;
            end
            U_START: begin
                // Mid start bit: a high line means the falling edge was a glitch
                if (zaehler == Z_HALB) begin
                    zaehler_n = '0;
                    bit_nr_n  = '0;
                    zustand_n = rx_p1 ? U_RUHE : U_DATEN;
                end
            end
            U_DATEN: begin
                if (zaehler == Z_BIT) begin
                    zaehler_n = '0;
                    schiebe_n = {rx_p1, schiebe[7:1]};
                    bit_nr_n  = bit_nr + 3'd1;
                    if (bit_nr == 3'd7) zustand_n = U_STOP;
                end
            end
            U_STOP: begin
                if (zaehler == Z_BIT) begin
                    zaehler_n = '0;
                    zustand_n = U_RUHE;
                    if (rx_p1) gueltig_n = 1'b1;
                    else       fehler_n  = 1'b1;
                end
            end
            default: zustand_n = U_RUHE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zustand      <= U_RUHE;
            zaehler      <= '0;
            bit_nr       <= '0;
            byte_gueltig <= 1'b0;
            rahmenfehler <= 1'b0;
        end else begin
            zustand      <= zustand_n;
            zaehler      <= zaehler_n;
            bit_nr       <= bit_nr_n;
            byte_gueltig <= gueltig_n;
            rahmenfehler <= fehler_n;
        end
    end

    always_ff @(posedge clk) begin
        schiebe <= schiebe_n;
    end

    assign empf_byte = schiebe;

endmodule

// File: rtl/instruktion_lader.sv
// UART boot loader: word count header, then little-endian words written
// into instruction RAM; releases the CPU reset after a hold time.
module instruktion_lader
    import instruktion_lader_pkg::*;
#(
    parameter int TAKTE_PRO_BIT = TAKTE_PRO_BIT_STD,
    parameter int ADRESSBREITE  = 8,
    parameter int WORTBREITE    = 32,
    parameter int NACHLAUF      = 10
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Rx,
    output logic [ADRESSBREITE-1:0] Adresse,
    output logic [WORTBREITE-1:0]   DatenRaus,
    output logic                    SchreibenAn,
    input  logic                    DatenGeschrieben,
    output logic                    CPUReset,
    output logic                    Laedt,
    output logic                    Fertig,
    output logic                    Fehler
);

    localparam int NW = $clog2(NACHLAUF + 1);
    localparam logic [NW-1:0] N_LETZT = NW'(NACHLAUF - 1);

    // Last address to write; a count of 0 (or beyond the RAM) fills the whole RAM
    function automatic logic [ADRESSBREITE-1:0] endadresse(input logic [7:0] n);
        longint tiefe;
        tiefe = longint'(1) << ADRESSBREITE;
        if (n == 8'd0 || longint'(n) > tiefe) return ADRESSBREITE'(tiefe - 1);
        return ADRESSBREITE'(longint'(n) - 1);
    endfunction

    logic [7:0] empf_byte;
    logic       byte_gueltig, rahmenfehler;

    instruktion_lader_uart_empfaenger #(
        .TAKTE_PRO_BIT(TAKTE_PRO_BIT)
    ) u_empfaenger (
        .clk         (Clock),
        .rst         (Reset),
        .rx          (Rx),
        .empf_byte   (empf_byte),
        .byte_gueltig(byte_gueltig),
        .rahmenfehler(rahmenfehler)
    );

    lader_zustand_t          zustand, zustand_n;
    logic [ADRESSBREITE-1:0] adresse, adresse_n;
    logic [ADRESSBREITE-1:0] endadr, endadr_n;
    logic [WORTBREITE-1:0]   daten, daten_n;
    logic [1:0]              idx, idx_n;
    logic [7:0]              puffer, puffer_n;
    logic                    puffer_voll, puffer_voll_n;
    logic                    fehler, fehler_n;
    logic [NW-1:0]           nach, nach_n;
    logic                    nimm;
    logic [7:0]              nimm_byte;

    always_comb begin
        zustand_n     = zustand;
        adresse_n     = adresse;
        endadr_n      = endadr;
        daten_n       = daten;
        idx_n         = idx;
        puffer_n      = puffer;
        puffer_voll_n = puffer_voll;
        fehler_n      = fehler;
        nach_n        = nach;
        nimm          = 1'b0;
        nimm_byte     = empf_byte;
        if (rahmenfehler && zustand != L_FERTIG) fehler_n = 1'b1;
        unique case (zustand)
            L_KOPF: begin
                if (byte_gueltig) begin
                    endadr_n  = endadresse(empf_byte);
                    zustand_n = L_SAMMELN;
                end
            end
            L_SAMMELN: begin
                // A byte parked during the write is consumed before new ones
                if (puffer_voll) begin
                    nimm          = 1'b1;
                    nimm_byte     = puffer;
                    puffer_voll_n = byte_gueltig;
                    if (byte_gueltig) puffer_n = empf_byte;
                end else if (byte_gueltig) begin
                    nimm = 1'b1;
                end
                if (nimm) begin
                    daten_n[{idx, 3'b000} +: 8] = nimm_byte;
                    idx_n = idx + 2'd1;
                    if (idx == 2'(BYTES_PRO_WORT - 1)) zustand_n = L_SCHREIBEN;
                end
            end
            L_SCHREIBEN: begin
                if (byte_gueltig) begin
                    if (puffer_voll) begin
                        fehler_n = 1'b1;
                    end else begin
                        puffer_n      = empf_byte;
                        puffer_voll_n = 1'b1;
                    end
                end
                if (DatenGeschrieben) begin
                    if (adresse == endadr) begin
                        nach_n    = '0;
                        zustand_n = L_NACHLAUF;
                    end else begin
                        adresse_n = adresse + ADRESSBREITE'(1);
                        zustand_n = L_SAMMELN;
                    end
                end
            end
            L_NACHLAUF: begin
                nach_n = nach + NW'(1);
                if (nach == N_LETZT) zustand_n = L_FERTIG;
            end
            L_FERTIG: ;
            default: zustand_n = L_KOPF;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand     <= L_KOPF;
            adresse     <= '0;
            endadr      <= '0;
            daten       <= '0;
            idx         <= '0;
            puffer_voll <= 1'b0;
            fehler      <= 1'b0;
            nach        <= '0;
        end else begin
            zustand     <= zustand_n;
            adresse     <= adresse_n;
            endadr      <= endadr_n;
            daten       <= daten_n;
            idx         <= idx_n;
            puffer_voll <= puffer_voll_n;
            fehler      <= fehler_n;
            nach        <= nach_n;
        end
    end

    always_ff @(posedge Clock) begin
        puffer <= puffer_n;
    end

    assign Adresse     = adresse;
    assign DatenRaus   = daten;
    assign SchreibenAn = (zustand == L_SCHREIBEN);
    assign CPUReset    = (zustand != L_FERTIG);
    assign Laedt       = (zustand == L_SAMMELN) || (zustand == L_SCHREIBEN);
    assign Fertig      = (zustand == L_FERTIG);
    assign Fehler      = fehler;

endmodule
